apb_cmd_sequencer: RTL

Upstream command stage for the APB add-master. Buffers read/write commands in a small FIFO, issues them one at a time on the master's `add_i`/`external_wdata_i` inputs, and tracks `ready_o`. It returns one response per command: the captured `rdata_o` for reads, or a completion for writes. The block is instantiated in front of `apb_master_slave_top` and wired port-to-port to it.

---
 rtl/apb_cmd_sequencer_if.sv | 35 +++
 rtl/apb_cmd_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/apb_cmd_sequencer_if.sv
// Command, APB-master and response signals of apb_cmd_sequencer.
// master: the sequencer's view; slave: the surrounding command source, APB master top and response sink.
interface apb_cmd_sequencer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic [1:0]        add_o;
    logic [DATA_W-1:0] wdata_o;
    logic              ready_i;
    logic [DATA_W-1:0] rdata_i;
    logic              rsp_valid_o;
    logic              rsp_write_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_err_o;
    logic [CNT_W-1:0]  count_o;
    logic              busy_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_wdata_i, ready_i, rdata_i,
        output cmd_ready_o, add_o, wdata_o, rsp_valid_o, rsp_write_o,
               rsp_data_o, rsp_err_o, count_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_wdata_i, ready_i, rdata_i,
        input  cmd_ready_o, add_o, wdata_o, rsp_valid_o, rsp_write_o,
               rsp_data_o, rsp_err_o, count_o, busy_o
    );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// Command FIFO plus IDLE/ISSUE/WAIT/CAPTURE sequencer feeding the APB add-master one command at a time.
// Optional WAIT-state timeout abort is built only when APB_SEQ_TIMEOUT_EN is defined.
module apb_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                preset_n,
    apb_cmd_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DATA_W != 32 || TIMEOUT < 1) begin : g_param_check
        $error("apb_cmd_sequencer: unsupported DEPTH/DATA_W/TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t            state_reg;
    logic              ready_en_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [1:0]        add_reg;
    logic              rsp_valid_reg;
    logic              rsp_write_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_err_reg;
    logic              busy_reg;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              write_mem [DEPTH];

    logic              cmd_ready;
    logic              push;
    logic              pop;
    logic              head_write;
    logic [DATA_W-1:0] head_data;
    logic              timeout_hit;

    // ready_en_reg keeps cmd_ready low through reset and for the edge that releases it.
    assign cmd_ready  = ready_en_reg && (count_reg != CNT_W'(DEPTH));
    assign push       = bus.cmd_valid_i && cmd_ready;
    assign head_write = write_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];
    assign pop        = (state_reg == CAPTURE) ||
                        ((state_reg == WAIT) && ((bus.ready_i && head_write) || timeout_hit));

    always_ff @(posedge pclk) begin
        if (push) begin
            data_mem[wr_ptr_reg]  <= bus.cmd_wdata_i;
            write_mem[wr_ptr_reg] <= bus.cmd_write_i;
        end
    end

`ifdef APB_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_reg;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg != WAIT || bus.ready_i) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

    assign timeout_hit = (state_reg == WAIT) && !bus.ready_i && (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg     <= IDLE;
            ready_en_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            add_reg       <= 2'b00;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            ready_en_reg  <= 1'b1;
            add_reg       <= 2'b00;
            rsp_valid_reg <= 1'b0;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);

            unique case (state_reg)
                IDLE: begin
                    if (count_reg != '0) begin
                        state_reg <= ISSUE;
                        add_reg   <= {head_write, 1'b1};
                        busy_reg  <= 1'b1;
                    end
                end
                ISSUE: state_reg <= WAIT;
                WAIT: begin
                    if (bus.ready_i) begin
                        if (head_write) begin
                            state_reg     <= IDLE;
                            busy_reg      <= 1'b0;
                            rsp_valid_reg <= 1'b1;
                            rsp_write_reg <= 1'b1;
                            rsp_err_reg   <= 1'b0;
                        end else begin
                            state_reg <= CAPTURE;
                        end
                    end else if (timeout_hit) begin
                        // Abort: response carries the error flag, read data is left as it was.
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_write_reg <= head_write;
                        rsp_err_reg   <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                    rsp_valid_reg <= 1'b1;
                    rsp_write_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    rsp_data_reg  <= bus.rdata_i;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.add_o       = add_reg;
    assign bus.wdata_o     = (count_reg != '0) ? head_data : '0;
    assign bus.rsp_valid_o = rsp_valid_reg;
    assign bus.rsp_write_o = rsp_write_reg;
    assign bus.rsp_data_o  = rsp_data_reg;
    assign bus.rsp_err_o   = rsp_err_reg;
    assign bus.count_o     = count_reg;
    assign bus.busy_o      = busy_reg;
endmodule
